// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Build option: DMEM_ARB_RR_EN selects round-robin arbitration.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    ARB    = 2'd0,
    HOLD_A = 2'd1,
    HOLD_B = 2'd2
  } arbState_t;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_A    = 2'd1;
  localparam logic [1:0] OWN_B    = 2'd2;

  localparam logic [2:0] HOLD_MAX = 3'd4;

endpackage

// File: rtl/dmem_arb_sel.sv
// Combinational request select: requests, state, pointer in; grants out.
// Build option: DMEM_ARB_RR_EN adds the round-robin pointer input.
module dmem_arb_sel
  import dmem_arb_pkg::*;
(
  input  logic       AReq,
  input  logic       BReq,
  input  logic [1:0] State,
`ifdef DMEM_ARB_RR_EN
  input  logic       RrPtr,
`endif
  output logic [1:0] Gnt
);

  // Grant vector: bit 0 = A, bit 1 = B; a hold locks out the other port
  always_comb begin
    Gnt = 2'b00;
    unique case (1'b1)
      (State == HOLD_A): Gnt[0] = AReq;
      (State == HOLD_B): Gnt[1] = BReq;
      default: begin
`ifdef DMEM_ARB_RR_EN
        if (AReq && BReq)
          Gnt = RrPtr ? 2'b10 : 2'b01;
        else
          Gnt = {BReq, AReq};
`else
        Gnt = {BReq & ~AReq, AReq};
`endif
      end
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-ported registered data memory.
// Build option: DMEM_ARB_RR_EN switches ARB from fixed to round-robin.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int MEM_AW = 10
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              AReq,
  input  logic              BReq,
  input  logic [31:0]       AAddr,
  input  logic [31:0]       BAddr,
  input  logic              AWrite,
  input  logic              BWrite,
  input  logic [31:0]       AWrData,
  input  logic [31:0]       BWrData,
  input  logic              ALock,
  input  logic              BLock,
  output logic              AGnt,
  output logic              BGnt,
  output logic              ARdValid,
  output logic              BRdValid,
  output logic [31:0]       ARdData,
  output logic [31:0]       BRdData,
  output logic              AAddrErr,
  output logic              BAddrErr,
  output logic [MEM_AW-1:0] MemAddr,
  output logic              MemWrite,
  output logic [31:0]       MemWrData,
  input  logic [31:0]       MemRdData
);

  arbState_t   stateQ, stateD;
  logic [2:0]  cntQ, cntD;
  logic [1:0]  ownerQ;
  logic        badQ;
  logic        aErrQ, bErrQ;
  logic [31:0] aDataQ, bDataQ;
  logic [1:0]  selGnt;
  logic        aBad, bBad;
  logic [31:0] rdWord;

`ifdef DMEM_ARB_RR_EN
  logic        ptrQ;
`endif

  assign aBad = (|AAddr[1:0]) | (|AAddr[31:MEM_AW+2]);
  assign bBad = (|BAddr[1:0]) | (|BAddr[31:MEM_AW+2]);

  dmem_arb_sel uSel (
    .AReq  (AReq),
    .BReq  (BReq),
    .State (stateQ),
`ifdef DMEM_ARB_RR_EN
    .RrPtr (ptrQ),
`endif
    .Gnt   (selGnt)
  );

  assign AGnt = selGnt[0] & ~Reset;
  assign BGnt = selGnt[1] & ~Reset;

  assign MemAddr   = BGnt ? BAddr[MEM_AW+1:2]
                          : AAddr[MEM_AW+1:2];
  assign MemWrData = BGnt ? BWrData : AWrData;
  assign MemWrite  = (AGnt & AWrite & ~aBad)
                   | (BGnt & BWrite & ~bBad);

  assign rdWord   = badQ ? 32'd0 : MemRdData;
  assign ARdValid = (ownerQ == OWN_A) & ~Reset;
  assign BRdValid = (ownerQ == OWN_B) & ~Reset;
  assign ARdData  = Reset    ? 32'd0
                  : ARdValid ? rdWord : aDataQ;
  assign BRdData  = Reset    ? 32'd0
                  : BRdValid ? rdWord : bDataQ;
  assign AAddrErr = aErrQ & ~Reset;
  assign BAddrErr = bErrQ & ~Reset;

  // Lock FSM: enter hold on a locked win, leave on unlock or timeout
  always_comb begin
    stateD = stateQ;
    cntD   = cntQ;
    unique case (stateQ)
      ARB: begin
        cntD = 3'd0;
        if (AGnt && ALock) begin
          stateD = HOLD_A;
          cntD   = 3'd1;
        end else if (BGnt && BLock) begin
          stateD = HOLD_B;
          cntD   = 3'd1;
        end
      end
      HOLD_A: begin
        if (!ALock || cntQ >= HOLD_MAX) begin
          stateD = ARB;
          cntD   = 3'd0;
        end else begin
          cntD = cntQ + 3'd1;
        end
      end
      HOLD_B: begin
        if (!BLock || cntQ >= HOLD_MAX) begin
          stateD = ARB;
          cntD   = 3'd0;
        end else begin
          cntD = cntQ + 3'd1;
        end
      end
      default: begin
        stateD = ARB;
        cntD   = 3'd0;
      end
    endcase
  end

  // State, in-flight load tag, error pulses and held read data
  always_ff @(posedge Clk) begin
    if (Reset) begin
      stateQ <= ARB;
      cntQ   <= 3'd0;
      ownerQ <= OWN_NONE;
      badQ   <= 1'b0;
      aErrQ  <= 1'b0;
      bErrQ  <= 1'b0;
      aDataQ <= 32'd0;
      bDataQ <= 32'd0;
    end else begin
      stateQ <= stateD;
      cntQ   <= cntD;
      if (AGnt && !AWrite)
        ownerQ <= OWN_A;
      else if (BGnt && !BWrite)
        ownerQ <= OWN_B;
      else
        ownerQ <= OWN_NONE;
      badQ  <= BGnt ? bBad : aBad;
      aErrQ <= AGnt & aBad;
      bErrQ <= BGnt & bBad;
      if (ARdValid)
        aDataQ <= rdWord;
      if (BRdValid)
        bDataQ <= rdWord;
    end
  end

`ifdef DMEM_ARB_RR_EN
  // Round-robin pointer moves to the port that lost
  always_ff @(posedge Clk) begin
    if (Reset)
      ptrQ <= 1'b0;
    else if (AGnt)
      ptrQ <= 1'b1;
    else if (BGnt)
      ptrQ <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter (default fixed-priority build).
// Includes a registered 1024x32 memory model.
module tb_dmem_arbiter;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        AReq, BReq;
  logic [31:0] AAddr, BAddr;
  logic        AWrite, BWrite;
  logic [31:0] AWrData, BWrData;
  logic        ALock, BLock;
  logic        AGnt, BGnt;
  logic        ARdValid, BRdValid;
  logic [31:0] ARdData, BRdData;
  logic        AAddrErr, BAddrErr;
  logic [9:0]  MemAddr;
  logic        MemWrite;
  logic [31:0] MemWrData;
  logic [31:0] MemRdData;

  logic [31:0] mem [1024];
  int nAssert = 0;
  int nFail   = 0;

  always #5 Clk = ~Clk;

  dmem_arbiter #(.MEM_AW(10)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .AReq      (AReq),
    .BReq      (BReq),
    .AAddr     (AAddr),
    .BAddr     (BAddr),
    .AWrite    (AWrite),
    .BWrite    (BWrite),
    .AWrData   (AWrData),
    .BWrData   (BWrData),
    .ALock     (ALock),
    .BLock     (BLock),
    .AGnt      (AGnt),
    .BGnt      (BGnt),
    .ARdValid  (ARdValid),
    .BRdValid  (BRdValid),
    .ARdData   (ARdData),
    .BRdData   (BRdData),
    .AAddrErr  (AAddrErr),
    .BAddrErr  (BAddrErr),
    .MemAddr   (MemAddr),
    .MemWrite  (MemWrite),
    .MemWrData (MemWrData),
    .MemRdData (MemRdData)
  );

  always @(posedge Clk) begin
    if (MemWrite)
      mem[MemAddr] <= MemWrData;
    MemRdData <= mem[MemAddr];
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    nAssert++;
    if (obs !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h",
               tag, obs, exp);
    end
  endtask

  task automatic idle();
    AReq = 0; BReq = 0;
    AWrite = 0; BWrite = 0;
    ALock = 0; BLock = 0;
    AAddr = 0; BAddr = 0;
    AWrData = 0; BWrData = 0;
  endtask

  task automatic mid();
    @(negedge Clk);
  endtask

  task automatic adv();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++)
      mem[i] = 32'd0;
    mem[4] = 32'hAAAA;
    mem[8] = 32'hBBBB;
    MemRdData = 32'd0;
    idle();
    Reset = 1;
    AReq = 1; AWrite = 1; AAddr = 32'h40;
    AWrData = 32'h5555;
    BReq = 1;
    adv();
    mid();
    chk("rst_agnt", AGnt, 0);
    chk("rst_bgnt", BGnt, 0);
    chk("rst_memwr", MemWrite, 0);
    chk("rst_avld", ARdValid, 0);
    chk("rst_adata", ARdData, 0);
    chk("rst_berr", BAddrErr, 0);
    adv();
    idle();
    Reset = 0;
    adv();

    // simultaneous loads, A wins
    AReq = 1; AAddr = 32'h10;
    BReq = 1; BAddr = 32'h20;
    mid();
    chk("sim_agnt", AGnt, 1);
    chk("sim_bgnt", BGnt, 0);
    chk("sim_maddr", MemAddr, 4);
    adv();
    AReq = 0;
    mid();
    chk("sim_avld", ARdValid, 1);
    chk("sim_adata", ARdData, 32'hAAAA);
    chk("sim_bgnt2", BGnt, 1);
    adv();
    idle();
    mid();
    chk("sim_bvld", BRdValid, 1);
    chk("sim_bdata", BRdData, 32'hBBBB);
    chk("sim_avld0", ARdValid, 0);
    chk("sim_ahold", ARdData, 32'hAAAA);
    adv();

    // store then load from A, no bubble
    AReq = 1; AWrite = 1; AAddr = 32'h40;
    AWrData = 32'h1234;
    mid();
    chk("st_gnt", AGnt, 1);
    chk("st_memwr", MemWrite, 1);
    chk("st_maddr", MemAddr, 16);
    chk("st_wdata", MemWrData, 32'h1234);
    adv();
    AWrite = 0;
    mid();
    chk("ld_gnt", AGnt, 1);
    chk("ld_memwr", MemWrite, 0);
    chk("st_novld", ARdValid, 0);
    adv();
    idle();
    mid();
    chk("ld_vld", ARdValid, 1);
    chk("ld_data", ARdData, 32'h1234);
    adv();

    // A lock for 3 cycles, B stalled
    AReq = 1; ALock = 1; AAddr = 32'h10;
    BReq = 1; BAddr = 32'h20;
    for (int i = 0; i < 3; i++) begin
      mid();
      chk("lk_agnt", AGnt, 1);
      chk("lk_bgnt", BGnt, 0);
      adv();
    end
    AReq = 0; ALock = 0;
    mid();
    chk("lk_fall_bgnt", BGnt, 0);
    adv();
    mid();
    chk("lk_after_bgnt", BGnt, 1);
    adv();
    idle();
    adv();

    // lock held 6 cycles, forced out after 4 in hold
    AReq = 1; ALock = 1; AAddr = 32'h10;
    BReq = 1; BAddr = 32'h20;
    for (int i = 0; i < 5; i++) begin
      mid();
      chk("to_bgnt0", BGnt, 0);
      adv();
    end
    AReq = 0;
    mid();
    chk("to_bgnt1", BGnt, 1);
    adv();
    idle();
    adv();
    adv();

    // bad addresses from B
    BReq = 1; BWrite = 1; BAddr = 32'h1002;
    BWrData = 32'hDEAD;
    mid();
    chk("ba_st_gnt", BGnt, 1);
    chk("ba_st_memwr", MemWrite, 0);
    chk("ba_st_err0", BAddrErr, 0);
    adv();
    BWrite = 0; BAddr = 32'h1000;
    mid();
    chk("ba_ld_gnt", BGnt, 1);
    chk("ba_ld_memwr", MemWrite, 0);
    chk("ba_st_err", BAddrErr, 1);
    adv();
    idle();
    mid();
    chk("ba_ld_err", BAddrErr, 1);
    chk("ba_ld_vld", BRdValid, 1);
    chk("ba_ld_data", BRdData, 0);
    adv();
    mid();
    chk("ba_err_end", BAddrErr, 0);
    chk("ba_mem0", mem[0], 0);
    adv();

    // reset with a load in flight
    AReq = 1; AAddr = 32'h10;
    mid();
    chk("rm_gnt", AGnt, 1);
    adv();
    idle();
    Reset = 1;
    mid();
    chk("rm_avld", ARdValid, 0);
    chk("rm_adata", ARdData, 0);
    adv();
    Reset = 0;
    mid();
    chk("rm_avld2", ARdValid, 0);
    chk("rm_adata2", ARdData, 0);
    chk("rm_memwr", MemWrite, 0);
    chk("rm_aerr", AAddrErr, 0);
    adv();

    // reset during a hold drops the lock
    AReq = 1; ALock = 1; AAddr = 32'h10;
    mid();
    chk("rh_agnt", AGnt, 1);
    adv();
    Reset = 1;
    adv();
    Reset = 0;
    AReq = 0;
    BReq = 1; BAddr = 32'h20;
    mid();
    chk("rh_bgnt", BGnt, 1);
    adv();
    idle();
    adv();

    $display("End of test - %0d assertions evaluated, %0d failures",
             nAssert, nFail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter: MEM_AW, 10, word-address width of the shared data memory (1024 x 32).
REQ-002 Clk  input  1  single clock; all state updates on posedge Clk.
REQ-003 Reset  input  1  reset, synchronous and active-high.
REQ-004 AReq/BReq  input  1 each  access request; A = pipeline MEM stage, B = loader/debug port.
REQ-005 AAddr/BAddr  input  32 each  byte address.
REQ-006 AWrite/BWrite  input  1 each  1 = store, 0 = load.
REQ-007 AWrData/BWrData  input  32 each  store data.
REQ-008 ALock/BLock  input  1 each  holds ownership for a read-modify-write sequence.
REQ-009 AGnt/BGnt  output  1 each  request accepted this cycle.
REQ-010 ARdValid/BRdValid  output  1 each  load data valid this cycle.
REQ-011 ARdData/BRdData  output  32 each  load data.
REQ-012 AAddrErr/BAddrErr  output  1 each  one-cycle pulse on a granted bad-address access.
REQ-013 MemAddr  output  MEM_AW  word address to memory.
REQ-014 MemWrite  output  1  write strobe to memory.
REQ-015 MemWrData  output  32  write data to memory.
REQ-016 MemRdData  input  32  memory read data, registered, valid one cycle after the address.

Function
REQ-017 At most one of AGnt/BGnt SHALL be high in any cycle; a grant is combinational from the current-cycle requests and state.
REQ-018 On grant, MemAddr SHALL be Addr[MEM_AW+1:2], MemWrData SHALL be WrData, and MemWrite SHALL be Write of the winner, all in the same cycle.
REQ-019 With no grant, MemWrite SHALL be 0; MemAddr and MemWrData are don't-care.
REQ-020 A granted load SHALL raise that port's RdValid exactly one cycle later, with RdData = MemRdData; a registered owner tag selects the port.
REQ-021 A granted store SHALL produce no RdValid.
REQ-022 RdData of a port SHALL hold its last value when RdValid is low.
REQ-023 Bad address: Addr[1:0] != 0 or Addr[31:MEM_AW+2] != 0.
REQ-024 A granted bad-address access SHALL force MemWrite to 0 and pulse AddrErr in the following cycle.
REQ-025 A granted bad-address load SHALL still return RdValid, with RdData = 0.
REQ-026 FSM states: ARB and HOLD_A / HOLD_B.
REQ-027 ARB: arbitrate per REQ-031. A winner with Lock = 1 SHALL move the FSM to HOLD_x.
REQ-028 HOLD_x: only port x can be granted; the other port SHALL be stalled (Gnt = 0) even if it requests.
REQ-029 HOLD_x SHALL return to ARB in the cycle after port x's Lock is 0.
REQ-030 HOLD_x SHALL NOT exceed 4 consecutive cycles; at the 4-cycle limit the FSM SHALL be forced back to ARB. A 3-bit hold counter implements this.
REQ-031 Arbitration, default: fixed priority, A over B.
REQ-032 Back-to-back grants SHALL be supported with no bubble, including a load followed immediately by a store.

Reset
REQ-033 While Reset is high, the following SHALL hold:
- FSM = ARB; owner tag cleared; hold counter = 0.
- All Gnt, RdValid and AddrErr = 0; RdData = 0; MemWrite = 0.
- RR pointer = A.
REQ-034 Reset asserted while a load is in flight SHALL suppress its RdValid.
REQ-035 Reset asserted in HOLD_x SHALL abandon the lock.

Configuration
REQ-036 Macro DMEM_ARB_RR_EN defined: ARB uses round-robin. The pointer SHALL toggle to the non-winner after each grant; on simultaneous requests the pointed-to port wins.
REQ-037 Macro DMEM_ARB_RR_EN undefined: fixed priority A > B; the RR pointer SHALL be absent.

Structure
REQ-038 A shared package dmem_arb_pkg SHALL hold:
- FSM state encoding;
- owner-tag constants (OWN_NONE, OWN_A, OWN_B);
- HOLD_MAX = 4.
REQ-039 The request-select logic SHALL be one sub-module, dmem_arb_sel. It is purely combinational: requests, state and pointer in; grant vector out.

Verification
REQ-040 Simultaneous loads: AReq = BReq = 1, both loads, AAddr = 0x10, BAddr = 0x20, mem[4] = 0xAAAA, mem[8] = 0xBBBB.
- Fixed priority: AGnt = 1, BGnt = 0; next cycle ARdValid = 1, ARdData = 0xAAAA; B is granted the following cycle.
- RR build: grants alternate A, B.
REQ-041 Store then load, back-to-back from A: store 0x1234 to 0x40, then load 0x40.
- Store cycle: MemWrite = 1, MemAddr = 16.
- Load returns 0x1234 with no bubble.
REQ-042 Lock: A holds ALock = 1 for 3 cycles while BReq = 1.
- BGnt = 0 throughout the lock.
- BGnt = 1 in the cycle after ALock falls.
- ALock held for 6 cycles: forced release after 4 cycles.
REQ-043 Bad address: B store to 0x1002 (misaligned) and B load from 0x1000 (out of range).
- MemWrite = 0 for both accesses.
- BAddrErr pulses once per access.
- The load gives BRdValid = 1 with BRdData = 0.
REQ-044 Reset mid-flight: Reset asserted the cycle after a granted load.
- ARdValid = 0.
- FSM = ARB.
- All outputs at reset values the next cycle.
